// File: rtl/bios_loader_if.sv
// Host byte streams and RAM port of the boot loader, bundled as one interface.
interface bios_loader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  o_read_req;
  logic [ADDR_WIDTH-1:0] o_read_addr;
  logic [DATA_WIDTH-1:0] i_read_data;
  logic                  o_write_enable;
  logic [NB-1:0]         o_byte_enable;
  logic [ADDR_WIDTH-1:0] o_write_addr;
  logic [DATA_WIDTH-1:0] o_write_data;
  logic [7:0]            i_data;
  logic                  i_valid;
  logic                  o_in_ready;
  logic [7:0]            o_data;
  logic                  o_valid;
  logic                  i_out_ready;

  modport slave (
    output o_read_req, o_read_addr, o_write_enable, o_byte_enable,
           o_write_addr, o_write_data, o_in_ready, o_data, o_valid,
    input  i_read_data, i_data, i_valid, i_out_ready
  );

  modport master (
    input  o_read_req, o_read_addr, o_write_enable, o_byte_enable,
           o_write_addr, o_write_data, o_in_ready, o_data, o_valid,
    output i_read_data, i_data, i_valid, i_out_ready
  );
endinterface

// File: rtl/bios_loader.sv
// Byte-command boot loader: burst RAM write/read with auto-increment, core reset/boot control.
// Read data 1 cycle after strobe; response bytes held while i_out_ready=0. BIOS_ACK_EN adds ACK bytes.
module bios_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  output logic          o_rst,
  output logic          o_booted,
  bios_loader_if.slave  bus
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int NA   = ADDR_WIDTH / 8;
  localparam int MAXB = (NA > NB) ? NA : NB;
  localparam int CW   = $clog2(MAXB + 1);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_BOOT  = 8'h01;
  localparam logic [7:0] OP_RST   = 8'h02;
  localparam logic [7:0] OP_SET   = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h04;
  localparam logic [7:0] OP_READ  = 8'h05;

  typedef enum logic [3:0] {
    S_IDLE, S_ARG_ADDR, S_ARG_CNT, S_WR_DATA, S_WR_COMMIT,
    S_RD_REQ, S_RD_WAIT, S_RD_SEND, S_DONE,
`ifdef BIOS_ACK_EN
    S_ACK,
`endif
    S_BOOTED
  } state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_ptr, r_addr_sh, w_addr_full;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata, w_wdata_next;
  logic [CW-1:0]         r_cnt;
  logic [8:0]            r_words;
  logic                  r_is_wr, r_rst, r_booted;
  logic                  w_in_fire, w_out_fire, w_last_arg, w_last_dat, w_last_word;
`ifdef BIOS_ACK_EN
  logic [7:0]            r_ack;
  logic                  r_boot_pend;
`endif

  assign w_in_fire   = bus.i_valid & bus.o_in_ready & clk_en;
  assign w_out_fire  = bus.o_valid & bus.i_out_ready & clk_en;
  assign w_last_arg  = (r_cnt == CW'(NA - 1));
  assign w_last_dat  = (r_cnt == CW'(NB - 1));
  assign w_last_word = (r_words == 9'd1);

  always_comb begin
    w_addr_full = r_addr_sh;
    w_addr_full[r_cnt*8 +: 8] = bus.i_data;
    w_wdata_next = r_wdata;
    w_wdata_next[r_cnt*8 +: 8] = bus.i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_state <= S_IDLE;
    else if (clk_en) r_state <= w_next;
  end

  always_comb begin
    w_next             = r_state;
    bus.o_in_ready     = 1'b0;
    bus.o_valid        = 1'b0;
    bus.o_data         = 8'h00;
    bus.o_read_req     = 1'b0;
    bus.o_write_enable = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.o_in_ready = 1'b1;
        if (w_in_fire) begin
          case (bus.i_data)
            OP_NOP, OP_RST:    w_next = S_DONE;
`ifdef BIOS_ACK_EN
            OP_BOOT:           w_next = S_ACK;
`else
            OP_BOOT:           w_next = S_BOOTED;
`endif
            OP_SET:            w_next = S_ARG_ADDR;
            OP_WRITE, OP_READ: w_next = S_ARG_CNT;
`ifdef BIOS_ACK_EN
            default:           w_next = S_ACK;
`else
            default:           w_next = S_IDLE;
`endif
          endcase
        end
      end
      S_ARG_ADDR: begin
        bus.o_in_ready = 1'b1;
        if (w_in_fire && w_last_arg) w_next = S_DONE;
      end
      S_ARG_CNT: begin
        bus.o_in_ready = 1'b1;
        if (w_in_fire) w_next = r_is_wr ? S_WR_DATA : S_RD_REQ;
      end
      S_WR_DATA: begin
        bus.o_in_ready = 1'b1;
        if (w_in_fire && w_last_dat) w_next = S_WR_COMMIT;
      end
      S_WR_COMMIT: begin
        bus.o_write_enable = clk_en;
        w_next = w_last_word ? S_DONE : S_WR_DATA;
      end
      S_RD_REQ: begin
        bus.o_read_req = clk_en;
        w_next = S_RD_WAIT;
      end
      S_RD_WAIT: w_next = S_RD_SEND;
      S_RD_SEND: begin
        bus.o_valid = 1'b1;
        bus.o_data  = r_rdata[7:0];
        if (w_out_fire && w_last_dat) w_next = w_last_word ? S_DONE : S_RD_REQ;
      end
`ifdef BIOS_ACK_EN
      S_DONE: w_next = S_ACK;
      S_ACK: begin
        bus.o_valid = 1'b1;
        bus.o_data  = r_ack;
        if (w_out_fire) w_next = r_boot_pend ? S_BOOTED : S_IDLE;
      end
`else
      S_DONE: w_next = S_IDLE;
`endif
      S_BOOTED: w_next = S_BOOTED;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_addr_sh   <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_cnt       <= '0;
      r_words     <= '0;
      r_is_wr     <= 1'b0;
      r_rst       <= 1'b0;
      r_booted    <= 1'b0;
`ifdef BIOS_ACK_EN
      r_ack       <= 8'h00;
      r_boot_pend <= 1'b0;
`endif
    end else begin
      // Self-clearing: the next edge after acceptance never sees another RST fire.
      r_rst <= w_in_fire && (r_state == S_IDLE) && (bus.i_data == OP_RST);
      if (clk_en) begin
        if (w_next == S_BOOTED) r_booted <= 1'b1;
        case (r_state)
          S_IDLE: if (w_in_fire) begin
            r_cnt   <= '0;
            r_is_wr <= (bus.i_data == OP_WRITE);
`ifdef BIOS_ACK_EN
            r_ack       <= (bus.i_data <= OP_READ) ? 8'hA5 : 8'hEE;
            r_boot_pend <= (bus.i_data == OP_BOOT);
`endif
          end
          S_ARG_ADDR: if (w_in_fire) begin
            r_addr_sh <= w_addr_full;
            r_cnt     <= r_cnt + 1'b1;
            if (w_last_arg) r_ptr <= w_addr_full;
          end
          S_ARG_CNT: if (w_in_fire) begin
            r_words <= (bus.i_data == 8'h00) ? 9'd256 : {1'b0, bus.i_data};
            r_cnt   <= '0;
          end
          S_WR_DATA: if (w_in_fire) begin
            r_wdata <= w_wdata_next;
            r_cnt   <= w_last_dat ? '0 : r_cnt + 1'b1;
          end
          S_WR_COMMIT: begin
            r_ptr   <= r_ptr + ADDR_WIDTH'(NB);
            r_words <= r_words - 9'd1;
          end
          S_RD_WAIT: begin
            r_rdata <= bus.i_read_data;
            r_cnt   <= '0;
          end
          S_RD_SEND: if (w_out_fire) begin
            r_rdata <= r_rdata >> 8;
            if (w_last_dat) begin
              r_cnt   <= '0;
              r_ptr   <= r_ptr + ADDR_WIDTH'(NB);
              r_words <= r_words - 9'd1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_read_addr   = r_ptr;
  assign bus.o_write_addr  = r_ptr;
  assign bus.o_write_data  = r_wdata;
  assign bus.o_byte_enable = {NB{bus.o_write_enable}};
  assign o_rst             = r_rst;
  assign o_booted          = r_booted;
endmodule
